// File: rtl/uart_alu_engine.sv
// Packet byte-stream ALU between a uart RX stream and TX stream: echo, add, multiply
// and (with UART_ALU_DIV_EN defined) restoring divide on little-endian operands.
module uart_alu_engine #(
   parameter int OP_WIDTH  = 32,
   parameter int LEN_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] pkt_cnt_o
);

   localparam int NB    = OP_WIDTH / 8;
   localparam int IDX_W = 4;

   localparam logic [7:0] OPC_ECHO = 8'h01;
   localparam logic [7:0] OPC_ADD  = 8'h02;
   localparam logic [7:0] OPC_MUL  = 8'h03;
`ifdef UART_ALU_DIV_EN
   localparam logic [7:0] OPC_DIV  = 8'h04;
   localparam int         DCNT_W   = $clog2(OP_WIDTH) + 1;
`endif

   typedef enum logic [3:0] {
      ST_OPCODE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_ECHO,
      ST_OPERAND,
      ST_RESULT,
      ST_DRAIN
`ifdef UART_ALU_DIV_EN
      , ST_DIVIDE
`endif
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             opcode_q, opcode_d;
   logic [7:0]             len_lo_q, len_lo_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [OP_WIDTH-1:0]    acc_q, acc_d;
   logic [OP_WIDTH-1:0]    stage_q, stage_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       res_idx_q, res_idx_d;
   logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;

   logic [LEN_WIDTH-1:0]   len_full;
   logic [OP_WIDTH-1:0]    byte_ext;
   logic [OP_WIDTH-1:0]    op_word;
   logic                   op_done;

`ifdef UART_ALU_DIV_EN
   logic [OP_WIDTH-1:0]    div_q, div_d;
   logic [OP_WIDTH-1:0]    rem_q, rem_d;
   logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
   logic [1:0]             op_cnt_q, op_cnt_d;
   logic [OP_WIDTH:0]      rem_shift;
   logic [OP_WIDTH:0]      div_diff;

   // One restoring step: a clear borrow bit means the trial subtraction fits.
   assign rem_shift = {rem_q, acc_q[OP_WIDTH-1]};
   assign div_diff  = rem_shift - {1'b0, div_q};
`endif

   assign len_full = LEN_WIDTH'({s_axis_tdata, len_lo_q});
   assign byte_ext = OP_WIDTH'(s_axis_tdata);
   // Bytes enter at the top so the operand is LSB-aligned once its last byte lands.
   assign op_word  = (stage_q >> 8) | (byte_ext << (OP_WIDTH - 8));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_OPCODE;
         opcode_q  <= '0;
         len_lo_q  <= '0;
         len_q     <= '0;
         acc_q     <= '0;
         stage_q   <= '0;
         idx_q     <= '0;
         res_idx_q <= '0;
         pkt_cnt_q <= '0;
`ifdef UART_ALU_DIV_EN
         div_q     <= '0;
         rem_q     <= '0;
         dcnt_q    <= '0;
         op_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         len_lo_q  <= len_lo_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         stage_q   <= stage_d;
         idx_q     <= idx_d;
         res_idx_q <= res_idx_d;
         pkt_cnt_q <= pkt_cnt_d;
`ifdef UART_ALU_DIV_EN
         div_q     <= div_d;
         rem_q     <= rem_d;
         dcnt_q    <= dcnt_d;
         op_cnt_q  <= op_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      len_lo_d      = len_lo_q;
      len_d         = len_q;
      acc_d         = acc_q;
      stage_d       = stage_q;
      idx_d         = idx_q;
      res_idx_d     = res_idx_q;
      pkt_cnt_d     = pkt_cnt_q;
      op_done       = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
`ifdef UART_ALU_DIV_EN
      div_d         = div_q;
      rem_d         = rem_q;
      dcnt_d        = dcnt_q;
      op_cnt_d      = op_cnt_q;
`endif

      case (state_q)
         ST_OPCODE: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               opcode_d = s_axis_tdata;
               state_d  = ST_RSVD;
            end
         end

         ST_RSVD: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) state_d = ST_LEN_LO;
         end

         ST_LEN_LO: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               len_lo_d = s_axis_tdata;
               state_d  = ST_LEN_HI;
            end
         end

         ST_LEN_HI: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               len_d     = len_full;
               idx_d     = '0;
               res_idx_d = '0;
               stage_d   = '0;
               case (opcode_q)
                  OPC_ECHO: begin
                     if (len_full == '0) begin
                        state_d   = ST_OPCODE;
                        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                     end else begin
                        state_d = ST_ECHO;
                     end
                  end
                  OPC_ADD: begin
                     acc_d   = '0;
                     state_d = (len_full == '0) ? ST_RESULT : ST_OPERAND;
                  end
                  OPC_MUL: begin
                     acc_d   = OP_WIDTH'(1);
                     state_d = (len_full == '0) ? ST_RESULT : ST_OPERAND;
                  end
`ifdef UART_ALU_DIV_EN
                  OPC_DIV: begin
                     acc_d    = '1;
                     op_cnt_d = 2'd0;
                     state_d  = (len_full == '0) ? ST_RESULT : ST_OPERAND;
                  end
`endif
                  default: begin
                     if (len_full == '0) begin
                        state_d   = ST_OPCODE;
                        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                     end else begin
                        state_d = ST_DRAIN;
                     end
                  end
               endcase
            end
         end

         ST_ECHO: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            if (s_axis_tvalid && m_axis_tready) begin
               len_d = len_q - LEN_WIDTH'(1);
               if (len_q == LEN_WIDTH'(1)) begin
                  state_d   = ST_OPCODE;
                  pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
               end
            end
         end

         ST_OPERAND: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               len_d   = len_q - LEN_WIDTH'(1);
               stage_d = op_word;
               op_done = (idx_q == IDX_W'(NB - 1));
               idx_d   = op_done ? '0 : idx_q + IDX_W'(1);
               if (op_done) begin
                  if (opcode_q == OPC_MUL) begin
                     acc_d = acc_q * op_word;
                  end
`ifdef UART_ALU_DIV_EN
                  else if (opcode_q == OPC_DIV) begin
                     if (op_cnt_q == 2'd0) acc_d = op_word;
                     else if (op_cnt_q == 2'd1) div_d = op_word;
                     if (op_cnt_q != 2'd2) op_cnt_d = op_cnt_q + 2'd1;
                  end
`endif
                  else begin
                     acc_d = acc_q + op_word;
                  end
               end
               if (len_q == LEN_WIDTH'(1)) begin
                  state_d = ST_RESULT;
`ifdef UART_ALU_DIV_EN
                  if (opcode_q == OPC_DIV) begin
                     if (op_cnt_d == 2'd2 && div_d != '0) begin
                        state_d = ST_DIVIDE;
                        rem_d   = '0;
                        dcnt_d  = '0;
                     end else begin
                        acc_d = '1;
                     end
                  end
`endif
               end
            end
         end

`ifdef UART_ALU_DIV_EN
         ST_DIVIDE: begin
            acc_d  = {acc_q[OP_WIDTH-2:0], ~div_diff[OP_WIDTH]};
            rem_d  = div_diff[OP_WIDTH] ? rem_shift[OP_WIDTH-1:0] : div_diff[OP_WIDTH-1:0];
            dcnt_d = dcnt_q + DCNT_W'(1);
            if (dcnt_q == DCNT_W'(OP_WIDTH - 1)) state_d = ST_RESULT;
         end
`endif

         ST_RESULT: begin
            // The accumulator doubles as the output shifter, so data holds under backpressure.
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = acc_q[7:0];
            if (m_axis_tready) begin
               acc_d = acc_q >> 8;
               if (res_idx_q == IDX_W'(NB - 1)) begin
                  state_d   = ST_OPCODE;
                  pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
               end else begin
                  res_idx_d = res_idx_q + IDX_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               len_d = len_q - LEN_WIDTH'(1);
               if (len_q == LEN_WIDTH'(1)) begin
                  state_d   = ST_OPCODE;
                  pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
               end
            end
         end

         default: state_d = ST_OPCODE;
      endcase
   end

   assign busy_o    = (state_q != ST_OPCODE);
   assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed bench for uart_alu_engine (OP_WIDTH=32): packet table with random
// backpressure, plus hand sequences for result latency, divide timing and reset.
module tb_uart_alu_engine;
   localparam int OPW = 32;
   localparam int NB  = OPW / 8;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        busy_o;
   logic [15:0] pkt_cnt_o;

   uart_alu_engine #(.OP_WIDTH(OPW), .LEN_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [127:0] ins;
      int           n_in;
      logic [31:0]  outs;
      int           n_out;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [7:0] bsel(input logic [127:0] v, input int n, input int i);
      return v[(n - 1 - i) * 8 +: 8];
   endfunction

   function automatic vec_t mk(input logic [127:0] ins, input int n_in,
                               input logic [31:0] outs, input int n_out);
      vec_t v;
      v.ins = ins; v.n_in = n_in; v.outs = outs; v.n_out = n_out;
      return v;
   endfunction

   // Source holds each byte until accepted; sink ready toggles randomly.
   task automatic run_pkt(input vec_t v, input int id);
      int         in_i = 0, out_n = 0, cyc = 0, idle = 0;
      logic [7:0] got [8];
      logic       s_fire, m_fire, hold;
      logic [7:0] hold_data;
      hold = 1'b0;
      hold_data = 8'h00;
      for (int k = 0; k < 8; k++) got[k] = 8'h00;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      while (cyc < 3000 && idle < 8) begin
         if (!s_axis_tvalid && in_i < v.n_in && $urandom_range(0, 3) != 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bsel(v.ins, v.n_in, in_i);
         end
         m_axis_tready = ($urandom_range(0, 2) != 0);
         #1;
         if (hold) begin
            chk($sformatf("vec%0d_hold_valid", id), m_axis_tvalid, 1'b1);
            chk($sformatf("vec%0d_hold_data", id), m_axis_tdata, hold_data);
         end
         s_fire    = s_axis_tvalid && s_axis_tready;
         m_fire    = m_axis_tvalid && m_axis_tready;
         hold      = m_axis_tvalid && !m_axis_tready;
         hold_data = m_axis_tdata;
         if (m_fire) begin
            if (out_n < 8) got[out_n] = m_axis_tdata;
            out_n++;
         end
         step();
         if (s_fire) begin
            in_i++;
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 8'h00;
         end
         if (in_i == v.n_in && out_n >= v.n_out && !busy_o) idle++;
         cyc++;
      end
      m_axis_tready = 1'b1;
      exp_cnt++;
      chk($sformatf("vec%0d_timeout", id), (cyc < 3000), 1'b1);
      chk($sformatf("vec%0d_out_count", id), out_n, v.n_out);
      for (int i = 0; i < v.n_out; i++)
         chk($sformatf("vec%0d_byte%0d", id, i), got[i], bsel(128'(v.outs), v.n_out, i));
      chk($sformatf("vec%0d_pkt_cnt", id), pkt_cnt_o, exp_cnt);
      chk($sformatf("vec%0d_busy", id), busy_o, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      #1;
      while (!s_axis_tready && t < 100) begin
         step();
         #1;
         t++;
      end
      if (t >= 100) chk("send_timeout", t, 0);
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
   endtask

   task automatic send_bytes(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(bsel(v, n, i));
   endtask

   initial begin
      int lat;
      logic [7:0] exp_b [4];
      rst_ni        = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      m_axis_tready = 1'b0;
      step();
      step();
      chk("rst_m_valid", m_axis_tvalid, 1'b0);
      chk("rst_m_data", m_axis_tdata, 8'h00);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_pkt_cnt", pkt_cnt_o, 16'd0);
      rst_ni = 1'b1;
      step();

      vecs.push_back(mk('h01_00_03_00_AA_BB_CC, 7, 'hAA_BB_CC, 3));
      vecs.push_back(mk('h02_00_08_00_01_00_00_00_FF_FF_FF_FF, 12, 'h00_00_00_00, 4));
      vecs.push_back(mk('h03_00_0A_00_03_00_00_00_05_00_00_00_EE_EE, 14, 'h0F_00_00_00, 4));
      vecs.push_back(mk('h7E_00_02_00_11_22, 6, '0, 0));
      vecs.push_back(mk('h01_00_01_00_5A, 5, 'h5A, 1));
      vecs.push_back(mk('h02_00_00_00, 4, 'h00_00_00_00, 4));
      vecs.push_back(mk('h03_00_00_00, 4, 'h01_00_00_00, 4));
      vecs.push_back(mk('h01_00_00_00, 4, '0, 0));
      vecs.push_back(mk('h7E_00_00_00, 4, '0, 0));
      vecs.push_back(mk(128'h02000C00_10000000_20000000_01020304, 16, 'h31_02_03_04, 4));
      vecs.push_back(mk('h03_00_08_00_00_00_01_00_00_00_01_00, 12, 'h00_00_00_00, 4));
      vecs.push_back(mk('h02_00_03_00_11_22_33, 7, 'h00_00_00_00, 4));
`ifdef UART_ALU_DIV_EN
      vecs.push_back(mk('h04_00_08_00_64_00_00_00_07_00_00_00, 12, 'h0E_00_00_00, 4));
      vecs.push_back(mk('h04_00_08_00_64_00_00_00_00_00_00_00, 12, 'hFF_FF_FF_FF, 4));
      vecs.push_back(mk('h04_00_04_00_05_00_00_00, 8, 'hFF_FF_FF_FF, 4));
`else
      vecs.push_back(mk('h04_00_02_00_11_22, 6, '0, 0));
`endif
      foreach (vecs[i]) run_pkt(vecs[i], i);

      // Result latency and stability with the sink stalled.
      m_axis_tready = 1'b0;
      send_bytes('h02_00_04_00_05_00_00_00, 8);
      #1;
      chk("lat_valid", m_axis_tvalid, 1'b1);
      chk("lat_data", m_axis_tdata, 8'h05);
      chk("lat_s_ready", s_axis_tready, 1'b0);
      chk("lat_busy", busy_o, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("stall_valid", m_axis_tvalid, 1'b1);
         chk("stall_data", m_axis_tdata, 8'h05);
      end
      exp_b = '{8'h05, 8'h00, 8'h00, 8'h00};
      m_axis_tready = 1'b1;
      for (int i = 0; i < NB; i++) begin
         #0;
         chk("drain_valid", m_axis_tvalid, 1'b1);
         chk("drain_data", m_axis_tdata, exp_b[i]);
         step();
         #1;
      end
      exp_cnt++;
      chk("b2b_s_ready", s_axis_tready, 1'b1);
      chk("b2b_busy", busy_o, 1'b0);
      chk("b2b_pkt_cnt", pkt_cnt_o, exp_cnt);

`ifdef UART_ALU_DIV_EN
      m_axis_tready = 1'b0;
      send_bytes('h04_00_08_00_64_00_00_00_07_00_00_00, 12);
      lat = 1;
      #1;
      while (!m_axis_tvalid && lat < 100) begin
         step();
         #1;
         lat++;
      end
      chk("div_latency", lat, OPW + 1);
      chk("div_first_byte", m_axis_tdata, 8'h0E);
      m_axis_tready = 1'b1;
      for (int i = 0; i < NB; i++) step();
      exp_cnt++;
      chk("div_pkt_cnt", pkt_cnt_o, exp_cnt);
`else
      lat = 0;
`endif

      // Reset in the middle of an operand, then a fresh packet.
      send_bytes('h02_00_08_00_01_00, 6);
      chk("mid_busy", busy_o, 1'b1);
      rst_ni = 1'b0;
      #2;
      chk("mid_rst_valid", m_axis_tvalid, 1'b0);
      chk("mid_rst_data", m_axis_tdata, 8'h00);
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_pkt_cnt", pkt_cnt_o, 16'd0);
      step();
      rst_ni = 1'b1;
      exp_cnt = 0;
      step();
      run_pkt(mk('h02_00_08_00_01_00_00_00_02_00_00_00, 12, 'h03_00_00_00, 4), 99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
